// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/loader RAM port arbiter.
// Optional build macro MEM_ARB_ROTATE_PRIO_EN selects alternating priority.
package mem_arb_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        CPU_WR = 2'd2,
        LDR_WR = 2'd3
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant decision between the CPU and the image loader.
// Fixed CPU priority by default; MEM_ARB_ROTATE_PRIO_EN alternates on contention.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic cpu_pend,
    input  logic ldr_pend,
`ifdef MEM_ARB_ROTATE_PRIO_EN
    input  logic last_grant,
`endif
    output logic gnt_valid,
    output logic gnt
);

    always_comb begin
        gnt_valid = cpu_pend | ldr_pend;
        gnt       = GNT_CPU;
        if (cpu_pend && ldr_pend) begin
`ifdef MEM_ARB_ROTATE_PRIO_EN
            // On contention hand the port to whoever did not have it last.
            gnt = (last_grant == GNT_CPU) ? GNT_LDR : GNT_CPU;
`else
            gnt = GNT_CPU;
`endif
        end else if (ldr_pend) begin
            gnt = GNT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the Z80 bus and the image loader.
// Optional build macro MEM_ARB_ROTATE_PRIO_EN enables alternating priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_wait_n,
    input  logic          ldr_req,
    input  logic [AW-1:0] ldr_addr,
    input  logic [7:0]    ldr_din,
    output logic          ldr_ack,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic [7:0]    mem_q
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cpu_dout_q, cpu_dout_d;
    logic             cpu_done_q, cpu_done_d;
    logic             ldr_ack_q, ldr_ack_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [7:0]       mem_din_q, mem_din_d;

    logic             cpu_pend;
    logic             gnt_valid;
    logic             gnt;
    logic             take_cpu;
    logic             take_ldr;

`ifdef MEM_ARB_ROTATE_PRIO_EN
    grant_e           last_grant_q, last_grant_d;
`endif

    assign cpu_pend = cpu_req & ~cpu_done_q;

    mem_arb_grant u_grant (
        .cpu_pend  (cpu_pend),
        .ldr_pend  (ldr_req),
`ifdef MEM_ARB_ROTATE_PRIO_EN
        .last_grant(last_grant_q),
`endif
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpu_dout_d = cpu_dout_q;
        cpu_done_d = cpu_done_q;
        ldr_ack_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        take_cpu   = 1'b0;
        take_ldr   = 1'b0;
`ifdef MEM_ARB_ROTATE_PRIO_EN
        last_grant_d = last_grant_q;
`endif

        if (!cpu_req) begin
            cpu_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                take_cpu = gnt_valid && (gnt == GNT_CPU);
                take_ldr = gnt_valid && (gnt == GNT_LDR);
            end
            CPU_WR: begin
                cpu_done_d = 1'b1;
                state_d    = IDLE;
            end
            CPU_RD: begin
                // The read completes even if the CPU has already let go of cpu_req.
                if (cnt_q == '0) begin
                    cpu_dout_d = mem_q;
                    cpu_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LDR_WR: begin
                // A CPU that arrived during the loader write goes straight in.
                state_d  = IDLE;
                take_cpu = cpu_pend;
            end
            default: state_d = IDLE;
        endcase

        if (take_cpu) begin
            mem_addr_d = cpu_addr;
            mem_din_d  = cpu_din;
            mem_we_d   = cpu_we;
            cnt_d      = CNT_W'(RD_LAT - 1);
            state_d    = cpu_we ? CPU_WR : CPU_RD;
`ifdef MEM_ARB_ROTATE_PRIO_EN
            last_grant_d = GNT_CPU;
`endif
        end

        if (take_ldr) begin
            mem_addr_d = ldr_addr;
            mem_din_d  = ldr_din;
            mem_we_d   = 1'b1;
            ldr_ack_d  = 1'b1;
            state_d    = LDR_WR;
`ifdef MEM_ARB_ROTATE_PRIO_EN
            last_grant_d = GNT_LDR;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cpu_dout_q <= 8'hFF;
            cpu_done_q <= 1'b0;
            ldr_ack_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
`ifdef MEM_ARB_ROTATE_PRIO_EN
            last_grant_q <= GNT_CPU;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_dout_q <= cpu_dout_d;
            cpu_done_q <= cpu_done_d;
            ldr_ack_q  <= ldr_ack_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
`ifdef MEM_ARB_ROTATE_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Wait is released while reset is held so a stalled CPU is not frozen by it.
    assign cpu_wait_n = reset | ~cpu_req | cpu_done_q;

    assign cpu_dout = cpu_dout_q;
    assign ldr_ack  = ldr_ack_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM and a shadow memory model.
// Expected priority ordering follows MEM_ARB_ROTATE_PRIO_EN when it is defined.
module tb_mem_port_arbiter;

    localparam int AW     = 16;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din, cpu_dout;
    logic          cpu_wait_n;
    logic          ldr_req;
    logic [AW-1:0] ldr_addr;
    logic [7:0]    ldr_din;
    logic          ldr_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic [7:0]    ram_q;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle_cnt    = 0;
    int we_count     = 0;
    logic [AW-1:0] last_we_addr;
    logic [7:0]    last_we_din;

    bit [7:0] ram       [65536];
    bit       ram_vld   [65536];
    bit [7:0] model_mem [65536];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_wait_n(cpu_wait_n),
        .ldr_req   (ldr_req),
        .ldr_addr  (ldr_addr),
        .ldr_din   (ldr_din),
        .ldr_ack   (ldr_ack),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_q     (ram_q)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h7C;
    endfunction

    // Single-port synchronous RAM, one registered read stage; power-up contents from init_val.
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (mem_we) begin
            ram[mem_addr]     <= mem_din;
            ram_vld[mem_addr] <= 1'b1;
        end
        ram_q <= ram_vld[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_count++;
            last_we_addr = mem_addr;
            last_we_din  = mem_din;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cpu(output int cycles);
        cycles = 0;
        #1;
        while (cpu_wait_n !== 1'b1 && cycles < 30) begin
            cycles++;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] din,
                              output int cycles, output logic [7:0] data,
                              output logic [7:0] exp_data, output int done_cycle);
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
        cpu_req  = 1'b1;
        wait_cpu(cycles);
        data       = cpu_dout;
        exp_data   = model_mem[addr];
        done_cycle = cycle_cnt;
        if (we) model_mem[addr] = din;
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic ldr_write(input logic [15:0] addr, input logic [7:0] din, output int ack_cycle);
        int n = 0;
        ldr_addr = addr;
        ldr_din  = din;
        ldr_req  = 1'b1;
        #1;
        while (ldr_ack !== 1'b1 && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("ldr_ack_seen", ldr_ack, 1);
        if (ldr_ack === 1'b1) model_mem[addr] = din;
        ack_cycle = cycle_cnt;
        tick();
        ldr_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wc, dc, ac, we0;
        logic [7:0] rd, ex;
        logic [15:0] a;

        for (int i = 0; i < 65536; i++) model_mem[i] = init_val(16'(i));
        reset    = 1'b1;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        ldr_req  = 1'b0;
        ldr_addr = '0;
        ldr_din  = '0;

        // Reset held, then released with everything idle.
        repeat (3) tick();
        checkOutput("t1_wait_n_rst", cpu_wait_n, 1);
        checkOutput("t1_dout_rst", cpu_dout, 8'hFF);
        checkOutput("t1_we_rst", mem_we, 0);
        checkOutput("t1_ack_rst", ldr_ack, 0);
        checkOutput("t1_addr_rst", mem_addr, 0);
        reset = 1'b0;
        repeat (5) tick();
        checkOutput("t1_we_count", we_count, 0);
        checkOutput("t1_wait_n", cpu_wait_n, 1);
        checkOutput("t1_dout", cpu_dout, 8'hFF);

        // Plain read of preloaded location.
        cpu_access(1'b0, 16'h1234, 8'h00, wc, rd, ex, dc);
        checkOutput("t2_wait", wc, RD_LAT + 1);
        checkOutput("t2_data", rd, 8'h5A);
        checkOutput("t2_wait_n", cpu_wait_n, 1);

        // Loader write followed by CPU read-back.
        we0 = we_count;
        ldr_write(16'h0100, 8'hA5, ac);
        checkOutput("t3_ack_pulse", ldr_ack, 0);
        checkOutput("t3_we_count", we_count - we0, 1);
        checkOutput("t3_we_addr", last_we_addr, 16'h0100);
        checkOutput("t3_we_din", last_we_din, 8'hA5);
        tick();
        tick();
        checkOutput("t3_we_single", we_count - we0, 1);
        cpu_access(1'b0, 16'h0100, 8'h00, wc, rd, ex, dc);
        checkOutput("t3_rd_wait", wc, RD_LAT + 1);
        checkOutput("t3_rd_data", rd, 8'hA5);

        // CPU write then read-back.
        we0 = we_count;
        cpu_access(1'b1, 16'h0300, 8'h3C, wc, rd, ex, dc);
        checkOutput("wr_wait", wc, 2);
        checkOutput("wr_we_count", we_count - we0, 1);
        checkOutput("wr_we_addr", last_we_addr, 16'h0300);
        cpu_access(1'b0, 16'h0300, 8'h00, wc, rd, ex, dc);
        checkOutput("wr_rd_data", rd, 8'h3C);

        // Simultaneous requests; the previous grant went to the CPU.
        fork
            cpu_access(1'b0, 16'h0100, 8'h00, wc, rd, ex, dc);
            ldr_write(16'h0200, 8'h77, ac);
        join
`ifdef MEM_ARB_ROTATE_PRIO_EN
        checkOutput("t4_cpu_wait", wc, RD_LAT + 2);
        checkOutput("t4_ldr_first", ac < dc, 1);
`else
        checkOutput("t4_cpu_wait", wc, RD_LAT + 1);
        checkOutput("t4_ldr_first", ac < dc, 0);
`endif
        checkOutput("t4_data", rd, 8'hA5);
        cpu_access(1'b0, 16'h0200, 8'h00, wc, rd, ex, dc);
        checkOutput("t4_ldr_data", rd, 8'h77);

        // Async reset in the middle of a read.
        we0      = we_count;
        cpu_we   = 1'b0;
        cpu_addr = 16'h1234;
        cpu_req  = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_wait_n", cpu_wait_n, 1);
        checkOutput("t5_dout", cpu_dout, 8'hFF);
        checkOutput("t5_we", mem_we, 0);
        checkOutput("t5_addr", mem_addr, 0);
        tick();
        reset = 1'b0;
        checkOutput("t5_no_we", we_count - we0, 0);
        wait_cpu(wc);
        checkOutput("t5_restart_wait", wc, RD_LAT + 1);
        checkOutput("t5_restart_data", cpu_dout, 8'h5A);
        cpu_req = 1'b0;
        tick();

        // Continuous loader stream with interleaved random CPU reads.
        we0 = we_count;
        fork
            begin
                int lac;
                for (int i = 0; i < 60; i++) begin
                    ldr_write(16'h4000 | 16'($urandom_range(0, 255)), 8'($urandom), lac);
                end
            end
            begin
                int cwc, cdc;
                logic [7:0] crd, cex;
                logic [15:0] ca;
                for (int j = 0; j < 12; j++) begin
                    repeat ($urandom_range(1, 3)) tick();
                    ca = 16'h4000 | 16'($urandom_range(0, 255));
                    cpu_access(1'b0, ca, 8'h00, cwc, crd, cex, cdc);
                    checkOutput("t6_latency", cwc <= RD_LAT + 2, 1);
                    checkOutput("t6_data", crd, cex);
                end
            end
        join
        checkOutput("t6_we_count", we_count - we0, 60);
        a = 16'h4000 | 16'($urandom_range(0, 255));
        cpu_access(1'b0, a, 8'h00, wc, rd, ex, dc);
        checkOutput("t6_final_data", rd, model_mem[a]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
